// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with scan-code-set-2 make/break/extended decoding
// into ten held-key levels for two players.
module ps2_key_decoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic       frame_err,
   output logic       p1_up,
   output logic       p1_down,
   output logic       p1_left,
   output logic       p1_right,
   output logic       p1_fire,
   output logic       p2_up,
   output logic       p2_down,
   output logic       p2_left,
   output logic       p2_right,
   output logic       p2_fire
);

   localparam int FLT_W = $clog2(FILTER_LEN + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;

   localparam int K_P1_UP    = 9;
   localparam int K_P1_DOWN  = 8;
   localparam int K_P1_LEFT  = 7;
   localparam int K_P1_RIGHT = 6;
   localparam int K_P1_FIRE  = 5;
   localparam int K_P2_UP    = 4;
   localparam int K_P2_DOWN  = 3;
   localparam int K_P2_LEFT  = 2;
   localparam int K_P2_RIGHT = 1;
   localparam int K_P2_FIRE  = 0;

   logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic             r_clk_filt;
   logic [FLT_W-1:0] r_flt_cnt;
   logic [1:0]       r_state;
   logic [3:0]       r_bit_cnt;
   logic [9:0]       r_shift;
   logic [TO_W-1:0]  r_to_cnt;
   logic             r_brk, r_ext;
   logic [9:0]       r_keys;
   logic [7:0]       r_scan_code;
   logic             r_code_valid, r_frame_err;
   logic             w_flt_flip, w_fall, w_frame_ok, w_timeout;

   // Idle-high PS/2 lines: synchronizers and filter come out of reset at 1
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   assign w_flt_flip = (r_clk_s2 != r_clk_filt) && (r_flt_cnt == FLT_W'(FILTER_LEN - 1));
   assign w_fall     = w_flt_flip && r_clk_filt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_clk_filt <= 1'b1;
         r_flt_cnt  <= '0;
      end else if (r_clk_s2 == r_clk_filt) begin
         r_flt_cnt  <= '0;
      end else if (w_flt_flip) begin
         r_clk_filt <= r_clk_s2;
         r_flt_cnt  <= '0;
      end else begin
         r_flt_cnt  <= r_flt_cnt + FLT_W'(1);
      end
   end

   // r_shift holds d0..d7 in [7:0], parity in [8], stop in [9]
   assign w_frame_ok = (^r_shift[8:0]) && r_shift[9];
   assign w_timeout  = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_to_cnt     <= '0;
         r_brk        <= 1'b0;
         r_ext        <= 1'b0;
         r_keys       <= '0;
         r_scan_code  <= '0;
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (w_fall || r_state != S_SHIFT)
            r_to_cnt <= '0;
         else
            r_to_cnt <= r_to_cnt + TO_W'(1);

         case (r_state)
            S_IDLE: begin
               if (w_fall && !r_dat_s2) begin
                  r_state   <= S_SHIFT;
                  r_bit_cnt <= 4'd1;
               end
            end
            S_SHIFT: begin
               if (w_fall) begin
                  r_shift   <= {r_dat_s2, r_shift[9:1]};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd10)
                     r_state <= S_CHECK;
               end else if (w_timeout) begin
                  r_frame_err <= 1'b1;
                  r_brk       <= 1'b0;
                  r_ext       <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_CHECK: begin
               r_state <= S_IDLE;
               if (w_frame_ok) begin
                  r_code_valid <= 1'b1;
                  r_scan_code  <= r_shift[7:0];
                  case (r_shift[7:0])
                     8'hF0: r_brk <= 1'b1;
                     8'hE0: r_ext <= 1'b1;
                     default: begin
                        r_brk <= 1'b0;
                        r_ext <= 1'b0;
                        // Keypad arrows arrive without E0 and must not drive p2
                        case (r_shift[7:0])
                           8'h1D: if (!r_ext) r_keys[K_P1_UP]    <= !r_brk;
                           8'h1B: if (!r_ext) r_keys[K_P1_DOWN]  <= !r_brk;
                           8'h1C: if (!r_ext) r_keys[K_P1_LEFT]  <= !r_brk;
                           8'h23: if (!r_ext) r_keys[K_P1_RIGHT] <= !r_brk;
                           8'h29: if (!r_ext) r_keys[K_P1_FIRE]  <= !r_brk;
                           8'h75: if (r_ext)  r_keys[K_P2_UP]    <= !r_brk;
                           8'h72: if (r_ext)  r_keys[K_P2_DOWN]  <= !r_brk;
                           8'h6B: if (r_ext)  r_keys[K_P2_LEFT]  <= !r_brk;
                           8'h74: if (r_ext)  r_keys[K_P2_RIGHT] <= !r_brk;
                           8'h5A: r_keys[K_P2_FIRE] <= !r_brk;
                           default: ;
                        endcase
                     end
                  endcase
               end else begin
                  r_frame_err <= 1'b1;
                  r_brk       <= 1'b0;
                  r_ext       <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign scan_code  = r_scan_code;
   assign code_valid = r_code_valid;
   assign frame_err  = r_frame_err;
   assign p1_up      = r_keys[K_P1_UP];
   assign p1_down    = r_keys[K_P1_DOWN];
   assign p1_left    = r_keys[K_P1_LEFT];
   assign p1_right   = r_keys[K_P1_RIGHT];
   assign p1_fire    = r_keys[K_P1_FIRE];
   assign p2_up      = r_keys[K_P2_UP];
   assign p2_down    = r_keys[K_P2_DOWN];
   assign p2_left    = r_keys[K_P2_LEFT];
   assign p2_right   = r_keys[K_P2_RIGHT];
   assign p2_fire    = r_keys[K_P2_FIRE];

endmodule
